// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand select codes,
// scoreboard state codes and the default register index width.
package fwd_hazard_unit_pkg;

    localparam int REG_AW_DEF         = 5;

    localparam int FWD_SEL_RF         = 0;
    localparam int FWD_SEL_STAGE_BASE = 1;

    localparam logic [0:0] SB_IDLE = 1'b0;
    localparam logic [0:0] SB_BUSY = 1'b1;

    // The multicycle result sits just past the last pipeline-stage code.
    function automatic int fwd_sel_mc(input int num_stages);
        return num_stages + FWD_SEL_STAGE_BASE;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source operand: youngest-first stage match, operand select and the
// hazard bit this source contributes to the pipeline stall.
module fwd_src_match
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 2)
) (
    input  logic                         fwd_en_i,
    input  logic [REG_AW-1:0]            src_i,
    input  logic                         src_valid_i,
    input  logic [NUM_STAGES*REG_AW-1:0] stage_dest_flat_i,
    input  logic [NUM_STAGES-1:0]        stage_wb_en_i,
    input  logic                         ex_mem_read_i,
    input  logic [REG_AW-1:0]            ex_dest_i,
    input  logic                         sb_busy_i,
    input  logic [REG_AW-1:0]            sb_pending_i,
    input  logic                         mc_byp_i,
    output logic [SEL_W-1:0]             sel_o,
    output logic                         hazard_o
);

    logic                  src_live_s;
    logic [NUM_STAGES-1:0] stage_hit_s;
    logic                  any_hit_s;
    logic [SEL_W-1:0]      hit_sel_s;
    logic                  load_use_s;
    logic                  pend_match_s;
    logic                  mc_fwd_s;

    assign src_live_s = src_valid_i && (src_i != {REG_AW{1'b0}});

    // Per-stage comparison of this source against each write-back destination
    always_comb begin
        stage_hit_s = {NUM_STAGES{1'b0}};
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_hit_s[k] = src_live_s && stage_wb_en_i[k] &&
                             (stage_dest_flat_i[k*REG_AW +: REG_AW] == src_i);
        end
    end

    // Oldest-to-youngest scan so the lowest (youngest) matching stage wins
    always_comb begin
        any_hit_s = 1'b0;
        hit_sel_s = SEL_W'(FWD_SEL_RF);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            any_hit_s = stage_hit_s[k] ? 1'b1 : any_hit_s;
            hit_sel_s = stage_hit_s[k] ? SEL_W'(k + FWD_SEL_STAGE_BASE) : hit_sel_s;
        end
    end

    assign load_use_s   = ex_mem_read_i && (ex_dest_i != {REG_AW{1'b0}}) &&
                          src_live_s && (src_i == ex_dest_i);
    assign pend_match_s = sb_busy_i && (sb_pending_i != {REG_AW{1'b0}}) &&
                          src_live_s && (src_i == sb_pending_i);
    assign mc_fwd_s     = mc_byp_i && pend_match_s;

    // Operand select: pipeline stages outrank the multicycle result
    always_comb begin
        if (fwd_en_i && any_hit_s) begin
            sel_o = hit_sel_s;
        end else if (mc_fwd_s) begin
            sel_o = SEL_W'(fwd_sel_mc(NUM_STAGES));
        end else begin
            sel_o = SEL_W'(FWD_SEL_RF);
        end
    end

    assign hazard_o = load_use_s || (!fwd_en_i && any_hit_s) || (pend_match_s && !mc_fwd_s);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use/interlock stall and fixed-latency MUL/DIV scoreboard.
// Optional macro FWD_MC_BYPASS_EN forwards the multicycle result on its done cycle.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NUM_STAGES = 2,
    parameter int MC_LAT     = 4,
    parameter int SEL_W      = $clog2(NUM_STAGES + 2)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fwd_en,
    input  logic [NUM_SRC*REG_AW-1:0]    src_flat,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_STAGES*REG_AW-1:0] stage_dest_flat,
    input  logic [NUM_STAGES-1:0]        stage_wb_en,
    input  logic                         ex_mem_read,
    input  logic [REG_AW-1:0]            ex_dest,
    input  logic                         mc_issue,
    input  logic [REG_AW-1:0]            mc_dest,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel_flat,
    output logic                         stall,
    output logic                         mc_busy,
    output logic                         mc_done,
    output logic [REG_AW-1:0]            mc_done_dest
);

    localparam int CNT_W = $clog2(MC_LAT);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] pend_q, pend_d;

    logic               busy_s;
    logic               done_s;
    logic               struct_haz_s;
    logic               mc_byp_s;
    logic [NUM_SRC-1:0] src_haz_s;

    assign busy_s       = (state_q == SB_BUSY);
    assign done_s       = busy_s && (cnt_q == {CNT_W{1'b0}});
    assign struct_haz_s = busy_s && (cnt_q != {CNT_W{1'b0}}) && mc_issue;

`ifdef FWD_MC_BYPASS_EN
    assign mc_byp_s = done_s && fwd_en;
`else
    assign mc_byp_s = 1'b0;
`endif

    // Scoreboard next state; an issue on the done cycle reloads back-to-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            SB_IDLE: begin
                if (mc_issue) begin
                    state_d = SB_BUSY;
                    cnt_d   = CNT_W'(MC_LAT - 1);
                    pend_d  = mc_dest;
                end else begin
                    state_d = SB_IDLE;
                end
            end
            SB_BUSY: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (mc_issue) begin
                    cnt_d  = CNT_W'(MC_LAT - 1);
                    pend_d = mc_dest;
                end else begin
                    state_d = SB_IDLE;
                end
            end
            default: begin
                state_d = SB_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                pend_d  = {REG_AW{1'b0}};
            end
        endcase
    end

    // Scoreboard state registers; reset drops any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            pend_q  <= {REG_AW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_src_match #(
            .REG_AW     (REG_AW),
            .NUM_STAGES (NUM_STAGES),
            .SEL_W      (SEL_W)
        ) u_match (
            .fwd_en_i          (fwd_en),
            .src_i             (src_flat[gi*REG_AW +: REG_AW]),
            .src_valid_i       (src_valid[gi]),
            .stage_dest_flat_i (stage_dest_flat),
            .stage_wb_en_i     (stage_wb_en),
            .ex_mem_read_i     (ex_mem_read),
            .ex_dest_i         (ex_dest),
            .sb_busy_i         (busy_s),
            .sb_pending_i      (pend_q),
            .mc_byp_i          (mc_byp_s),
            .sel_o             (fwd_sel_flat[gi*SEL_W +: SEL_W]),
            .hazard_o          (src_haz_s[gi])
        );
    end

    assign stall        = (|src_haz_s) || struct_haz_s;
    assign mc_busy      = busy_s;
    assign mc_done      = done_s;
    assign mc_done_dest = done_s ? pend_q : {REG_AW{1'b0}};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus pushes expectations, a
// negedge monitor pops and compares; mc_done pulses are checked against a dest queue.
module tb_fwd_hazard_unit;

    localparam int NUM_SRC    = 3;
    localparam int REG_AW     = 5;
    localparam int NUM_STAGES = 2;
    localparam int MC_LAT     = 4;
    localparam int SEL_W      = 2;

`ifdef FWD_MC_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic                         fwd_en;
    logic [NUM_SRC*REG_AW-1:0]    src_flat;
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_STAGES*REG_AW-1:0] stage_dest_flat;
    logic [NUM_STAGES-1:0]        stage_wb_en;
    logic                         ex_mem_read;
    logic [REG_AW-1:0]            ex_dest;
    logic                         mc_issue;
    logic [REG_AW-1:0]            mc_dest;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel_flat;
    logic                         stall;
    logic                         mc_busy;
    logic                         mc_done;
    logic [REG_AW-1:0]            mc_done_dest;

    fwd_hazard_unit #(
        .NUM_SRC    (NUM_SRC),
        .REG_AW     (REG_AW),
        .NUM_STAGES (NUM_STAGES),
        .MC_LAT     (MC_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fwd_en          (fwd_en),
        .src_flat        (src_flat),
        .src_valid       (src_valid),
        .stage_dest_flat (stage_dest_flat),
        .stage_wb_en     (stage_wb_en),
        .ex_mem_read     (ex_mem_read),
        .ex_dest         (ex_dest),
        .mc_issue        (mc_issue),
        .mc_dest         (mc_dest),
        .fwd_sel_flat    (fwd_sel_flat),
        .stall           (stall),
        .mc_busy         (mc_busy),
        .mc_done         (mc_done),
        .mc_done_dest    (mc_done_dest)
    );

    typedef struct {
        string      nm;
        logic [5:0] sel;
        logic       stall;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] done_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: compares every presented cycle and every mc_done pulse
    initial begin
        exp_t       e;
        logic [4:0] d;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".sel"},   32'(fwd_sel_flat), 32'(e.sel));
                chk({e.nm, ".stall"}, 32'(stall),        32'(e.stall));
                chk({e.nm, ".busy"},  32'(mc_busy),      32'(e.busy));
                chk({e.nm, ".done"},  32'(mc_done),      32'(e.done));
            end
            if (mc_done === 1'b1) begin
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    chk("mc_done_dest", 32'(mc_done_dest), 32'(d));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mc_done: got pulse dest %0d required no pulse", mc_done_dest);
                end
            end
        end
    end

    task automatic clr();
        fwd_en          = 1'b1;
        src_flat        = '0;
        src_valid       = '0;
        stage_dest_flat = '0;
        stage_wb_en     = '0;
        ex_mem_read     = 1'b0;
        ex_dest         = '0;
        mc_issue        = 1'b0;
        mc_dest         = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] v);
        src_flat[i*REG_AW +: REG_AW] = v;
    endtask

    task automatic set_stage(input int k, input logic [4:0] v);
        stage_dest_flat[k*REG_AW +: REG_AW] = v;
    endtask

    task automatic cyc(input string nm, input logic [5:0] s, input logic st,
                       input logic b, input logic d);
        exp_t e;
        e.nm = nm; e.sel = s; e.stall = st; e.busy = b; e.done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 6'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Forwarding priority and register-0 / invalid-source rules
        clr(); set_src(0, 5'd5); src_valid = 3'b001;
        set_stage(0, 5'd5); set_stage(1, 5'd5); stage_wb_en = 2'b11;
        cyc("mem_priority", 6'b000001, 1'b0, 1'b0, 1'b0);
        set_stage(0, 5'd6);
        cyc("wb_only", 6'b000010, 1'b0, 1'b0, 1'b0);
        clr(); set_src(1, 5'd0); src_valid = 3'b010; stage_wb_en = 2'b01;
        cyc("r0_no_fwd", 6'd0, 1'b0, 1'b0, 1'b0);
        clr(); set_src(1, 5'd7); src_valid = 3'b101; set_stage(0, 5'd7); stage_wb_en = 2'b01;
        cyc("invalid_src", 6'd0, 1'b0, 1'b0, 1'b0);
        src_valid = 3'b010; set_stage(1, 5'd7); stage_wb_en = 2'b10;
        cyc("src1_wb", 6'b001000, 1'b0, 1'b0, 1'b0);

        // Load-use and interlock-only mode
        clr(); ex_mem_read = 1'b1; ex_dest = 5'd9; set_src(2, 5'd9); src_valid = 3'b100;
        cyc("load_use", 6'd0, 1'b1, 1'b0, 1'b0);
        ex_mem_read = 1'b0;
        cyc("load_use_clear", 6'd0, 1'b0, 1'b0, 1'b0);
        ex_mem_read = 1'b1; ex_dest = 5'd0; set_src(2, 5'd0);
        cyc("load_r0", 6'd0, 1'b0, 1'b0, 1'b0);
        clr(); fwd_en = 1'b0; set_stage(1, 5'd3); stage_wb_en = 2'b10;
        set_src(0, 5'd3); src_valid = 3'b001;
        cyc("interlock", 6'd0, 1'b1, 1'b0, 1'b0);
        fwd_en = 1'b1;
        cyc("interlock_fwd_on", 6'b000010, 1'b0, 1'b0, 1'b0);

        // Multicycle op: latency, RAW stall, structural stall, back-to-back issue
        clr(); mc_issue = 1'b1; mc_dest = 5'd12; done_q.push_back(5'd12);
        cyc("mc_c0", 6'd0, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b0; set_src(0, 5'd12); src_valid = 3'b001;
        cyc("mc_c1", 6'd0, 1'b1, 1'b1, 1'b0);
        mc_issue = 1'b1; mc_dest = 5'd20;
        cyc("mc_c2_struct", 6'd0, 1'b1, 1'b1, 1'b0);
        mc_issue = 1'b0;
        cyc("mc_c3", 6'd0, 1'b1, 1'b1, 1'b0);
        mc_issue = 1'b1; mc_dest = 5'd20; done_q.push_back(5'd20);
        cyc("mc_c4_done", BYP ? 6'b000011 : 6'd0, !BYP, 1'b1, 1'b1);
        mc_issue = 1'b0; set_src(0, 5'd20);
        cyc("mc_c5_raw", 6'd0, 1'b1, 1'b1, 1'b0);
        src_valid = 3'b000;
        cyc("mc_c6", 6'd0, 1'b0, 1'b1, 1'b0);
        cyc("mc_c7", 6'd0, 1'b0, 1'b1, 1'b0);
        cyc("mc_c8_done", 6'd0, 1'b0, 1'b1, 1'b1);
        cyc("mc_c9_idle", 6'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation drops the pending op
        clr(); mc_issue = 1'b1; mc_dest = 5'd15;
        cyc("rst_c0", 6'd0, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b0;
        cyc("rst_c1", 6'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("rst_c2", 6'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; set_src(0, 5'd15); src_valid = 3'b001;
        for (int i = 0; i < 6; i++) begin
            cyc("rst_after", 6'd0, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        #1;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined MIPS core. It generalises operand forwarding to any number of source operands and forwarding stages. It adds load-use stall detection and a scoreboard for one multicycle execution unit (MUL/DIV) with fixed latency. It sits beside the ID/EX boundary and drives operand mux selects plus the pipeline stall line.

Parameters:
NUM_SRC, 3, number of source operands checked per instruction
REG_AW, 5, register index width
NUM_STAGES, 2, forwarding stages; index 0 = youngest (MEM), index NUM_STAGES-1 = oldest (WB)
MC_LAT, 4, multicycle unit latency in cycles (>=2)
SEL_W, $clog2(NUM_STAGES+2), select width per source (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset
fwd_en  in  1  forwarding enable
src_flat  in  NUM_SRC*REG_AW  source register indices; src i = bits [i*REG_AW +: REG_AW]
src_valid  in  NUM_SRC  source i is actually read
stage_dest_flat  in  NUM_STAGES*REG_AW  destination index per forwarding stage
stage_wb_en  in  NUM_STAGES  write-back enable per stage
ex_mem_read  in  1  instruction in EX is a load
ex_dest  in  REG_AW  destination of the instruction in EX
mc_issue  in  1  request to start a multicycle op this cycle
mc_dest  in  REG_AW  destination of the issued multicycle op
fwd_sel_flat  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k+1 = stage k, NUM_STAGES+1 = multicycle result
stall  out  1  freeze IF/ID, insert bubble into EX
mc_busy  out  1  multicycle op in flight
mc_done  out  1  one-cycle pulse: result valid this cycle
mc_done_dest  out  REG_AW  destination of the completing op

Behaviour:
- Reset: synchronous, active-high, on rising clk. Scoreboard returns to IDLE, counter = 0, pending dest = 0, mc_busy = 0, mc_done = 0, mc_done_dest = 0.
- Forwarding (combinational):
  - Source i matches stage k when src_valid[i], src != 0, stage_wb_en[k] and stage_dest[k] == src.
  - The lowest matching k wins (youngest value); sel = k+1.
  - No match, or fwd_en = 0: sel = 0.
  - Register 0 is never forwarded and never causes a stall.
- Load-use hazard: when ex_mem_read = 1 and ex_dest != 0 equals any valid source, stall = 1 combinationally for that cycle. Applies regardless of fwd_en.
- fwd_en = 0: any valid, nonzero source matching any stage with stage_wb_en = 1 also asserts stall (interlock-only mode).
- Scoreboard FSM with states IDLE and BUSY:
  - IDLE, mc_issue = 1: next state BUSY; counter <= MC_LAT-1; pending <= mc_dest. mc_busy is registered and rises the next cycle.
  - BUSY, counter != 0: counter decrements each cycle.
  - BUSY, counter == 0: mc_done = 1 and mc_done_dest = pending (both combinational from state). Next state is IDLE, unless mc_issue = 1, in which case the new op is accepted back-to-back: stay BUSY, reload counter and pending.
  - BUSY, counter != 0, mc_issue = 1: structural hazard. stall = 1 and the issue is ignored; upstream holds mc_issue.
  - In BUSY, a valid source matching pending (nonzero) asserts stall, except on the mc_done cycle when the optional feature is compiled in.
- Overall: stall = OR of all stall terms.
- Result latency: op issued at cycle t gives mc_done at cycle t+MC_LAT.
- Reset mid-operation: pending op is dropped; mc_done never fires for it.

Optional Feature:
FWD_MC_BYPASS_EN
- Defined: on the mc_done cycle, a source matching mc_done_dest (nonzero) gets sel = NUM_STAGES+1 and the scoreboard RAW stall is suppressed. A pipeline-stage match still takes priority over the multicycle result.
- Undefined: sel never takes the value NUM_STAGES+1. The scoreboard RAW stall holds through the mc_done cycle, and the value is read from the register file afterwards.

Decomposition:
- Shared package/header holds:
  - select encodings (FWD_SEL_RF = 0, stage base offset, multicycle code)
  - the scoreboard state encodings IDLE and BUSY
  - the REG_AW default
- One sub-module, fwd_src_match, is instantiated NUM_SRC times. It contains one source's priority match over the stages and produces sel plus a per-source hazard bit.

Test Plan:
- src0 = 5, stage_dest = {MEM = 5, WB = 5}, both wb_en = 1, fwd_en = 1 -> sel0 = 1 (MEM wins), stall = 0.
- src1 = 0, MEM dest = 0, wb_en = 1 -> sel1 = 0, stall = 0. Repeat with src_valid[1] = 0 and src1 = 7, MEM dest = 7 -> sel1 = 0.
- ex_mem_read = 1, ex_dest = 9, src2 = 9 valid -> stall = 1 for exactly that cycle. With fwd_en = 0 and WB dest = 3 matching src0 = 3 -> stall = 1, all sel = 0.
- mc_issue, mc_dest = 12 at cycle 0, MC_LAT = 4 -> mc_busy high cycles 1-4, mc_done pulse at cycle 4 with mc_done_dest = 12. src0 = 12 stalls cycles 1-3; cycle 4 stalls only without FWD_MC_BYPASS_EN, and with it sel0 = 3.
- mc_issue again at cycle 2 -> stall = 1, issue ignored. mc_issue held at cycle 4 -> accepted back-to-back, next mc_done at cycle 8.
- rst asserted at cycle 2 of an op -> mc_busy = 0 next cycle, no mc_done ever observed for it.
